// File: rtl/instr_fetch_queue.sv
// Circular instruction queue between fetch and decode: multi-slot push of fetch packets,
// in-order presentation of the oldest DECODE_NUM entries with variable-count retire.
module instr_fetch_queue #(
    parameter int DECODE_NUM = 4,
    parameter int FETCH_NUM  = 4,
    parameter int DEPTH      = 64,
    parameter int PC_W       = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              fetch_valid,
    output logic                              fetch_ready,
    input  logic [PC_W-1:0]                   fetch_pc,
    input  logic [FETCH_NUM*32-1:0]           fetch_instr,
    input  logic [FETCH_NUM-1:0]              fetch_mask,
    output logic [DECODE_NUM*32-1:0]          dec_instr,
    output logic [DECODE_NUM*PC_W-1:0]        dec_pc,
    output logic [DECODE_NUM-1:0]             dec_valid,
    input  logic [$clog2(DECODE_NUM+1)-1:0]   dec_accept,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(FETCH_NUM+1);

    function automatic logic [CNT_W-1:0] popcount(input logic [FETCH_NUM-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < FETCH_NUM; i++) begin
            c = c + CNT_W'(m[i]);
        end
        return c;
    endfunction

    logic [31:0]      instr_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic [CNT_W-1:0] n_push;
    logic [OCC_W-1:0] n_pop;

    // Ready looks only at registered occupancy, so a same-cycle pop never raises it.
    assign fetch_ready = (occupancy <= OCC_W'(DEPTH - FETCH_NUM));
    assign push        = fetch_valid && fetch_ready && !flush;
    assign n_push      = push ? popcount(fetch_mask) : '0;

    always_comb begin
        n_pop = OCC_W'(dec_accept);
        if (n_pop > occupancy) begin
            n_pop = occupancy;
        end
        if (n_pop > OCC_W'(DECODE_NUM)) begin
            n_pop = OCC_W'(DECODE_NUM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            rd_ptr    <= rd_ptr + PTR_W'(n_pop);
            wr_ptr    <= wr_ptr + PTR_W'(n_push);
            occupancy <= occupancy + OCC_W'(n_push) - n_pop;
        end
    end

    // Entry storage is data only; pointer arithmetic wraps naturally at DEPTH.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_NUM; i++) begin
            if (i < int'(n_push)) begin
                instr_mem[wr_ptr + PTR_W'(i)] <= fetch_instr[32*i +: 32];
                pc_mem[wr_ptr + PTR_W'(i)]    <= fetch_pc + PC_W'(4*i);
            end
        end
    end

    for (genvar j = 0; j < DECODE_NUM; j++) begin : g_slot
        logic [PTR_W-1:0] idx;
        assign idx                       = rd_ptr + PTR_W'(j);
        assign dec_instr[32*j +: 32]     = instr_mem[idx];
        assign dec_pc[PC_W*j +: PC_W]    = pc_mem[idx];
        assign dec_valid[j]              = (OCC_W'(j) < occupancy);
    end

endmodule
